// File: rtl/vx_stage_buf.sv
// vx_stage_buf: valid/ready front-end stage buffer with 2-entry skid, per-warp flush and bubble drop.
module vx_stage_buf #(
  parameter int INST_W  = 32,
  parameter int PC_W    = 32,
  parameter int NT      = 4,
  parameter int NW_BITS = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INST_W-1:0]  in_instruction,
  input  logic [PC_W-1:0]    in_curr_PC,
  input  logic [NT-1:0]      in_thread_mask,
  input  logic [NW_BITS-1:0] in_warp_num,
  input  logic               in_flush,
  input  logic               in_flush_all,
  input  logic [NW_BITS-1:0] in_flush_warp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INST_W-1:0]  out_instruction,
  output logic [PC_W-1:0]    out_curr_PC,
  output logic [NT-1:0]      out_thread_mask,
  output logic [NW_BITS-1:0] out_warp_num,
  output logic [1:0]         out_count,
  output logic [CNT_W-1:0]   out_drop_count
);
  localparam int PW = INST_W + PC_W + NT + NW_BITS;
  logic [PW-1:0] h_q, s_q, h1, h2, h_d, s_d, in_p;
  logic [1:0] count_q, count_d, ndrop;
  logic ready_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W:0] dsum;
  logic pop, push, hv1, sv1, hit_h, hit_s, hit_i, hk, sk, hv2, sv2, pkeep, hv3, sv3;
  assign in_p  = {in_instruction, in_curr_PC, in_thread_mask, in_warp_num};
  assign push  = in_valid & ready_q;
  assign pop   = (count_q != 2'd0) & out_ready;
  // pop first: S slides into H
  assign hv1   = pop ? (count_q == 2'd2) : (count_q != 2'd0);
  assign sv1   = (count_q == 2'd2) & ~pop;
  assign h1    = pop ? s_q : h_q;
  assign hit_h = in_flush & (in_flush_all | (h1[NW_BITS-1:0] == in_flush_warp));
  assign hit_s = in_flush & (in_flush_all | (s_q[NW_BITS-1:0] == in_flush_warp));
  assign hit_i = in_flush & (in_flush_all | (in_warp_num == in_flush_warp));
  assign hk    = hv1 & ~hit_h;
  assign sk    = sv1 & ~hit_s;
  // flush survivors compact toward H
  assign hv2   = hk | sk;
  assign sv2   = hk & sk;
  assign h2    = hk ? h1 : s_q;
  assign pkeep = push & ~hit_i & (|in_thread_mask);
  assign hv3   = hv2 | pkeep;
  assign sv3   = sv2 | (hv2 & pkeep);
  assign h_d   = hv2 ? h2 : (pkeep ? in_p : h_q);
  assign s_d   = (hv2 & pkeep) ? in_p : s_q;
  assign count_d = sv3 ? 2'd2 : (hv3 ? 2'd1 : 2'd0);
  assign ndrop = 2'(hv1 & hit_h) + 2'(sv1 & hit_s) + 2'(push & ~pkeep);
  assign dsum  = {1'b0, drop_q} + (CNT_W+1)'(ndrop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      s_q     <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      h_q     <= h_d;
      s_q     <= s_d;
      count_q <= count_d;
      ready_q <= ~sv3;
      drop_q  <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
    end
  end
  assign in_ready        = ready_q;
  assign out_valid       = count_q != 2'd0;
  assign out_count       = count_q;
  assign out_drop_count  = drop_q;
  assign {out_instruction, out_curr_PC, out_thread_mask, out_warp_num} = h_q;
endmodule
